// File: rtl/kfmmc_data_serial.sv
// kfmmc_data_serial
// Bit-level DAT0 engine for the MMC data path. Each request moves one byte,
// MSB first, over mmc_clock / DAT0. Receives can optionally hunt for a
// 0 start bit first. A running CRC16-CCITT is kept over every data bit.
//
// Ports:
//   clock, reset             system clock, async active-high reset
//   start_communication      one-cycle request, honoured only in IDLE
//   data_io                  0 = send, 1 = receive (sampled with start)
//   check_data_start_bit     receive only: hunt for start bit first
//   clear_data_crc           zero the CRC before this byte
//   clear_data_interrupt     clear both completion flags
//   mask_data_interrupt      gate interrupt outputs low (flags kept)
//   set_send_data, send_data load the transmit register
//   received_data            last received byte
//   data_crc                 running CRC16
//   is_in_connecting         transfer in progress
//   sent_data_interrupt      send-complete flag, masked
//   received_data_interrupt  receive-complete flag, masked
//   start_bit_timeout        sticky start-bit hunt timeout
//   mmc_clock                MMC clock, idles high
//   mmc_data_out, mmc_data_oe, mmc_data_in   DAT0 pin signals
module kfmmc_data_serial #(
    parameter int CLOCK_DIV     = 1,
    parameter int START_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_communication,
    input  logic        data_io,
    input  logic        check_data_start_bit,
    input  logic        clear_data_crc,
    input  logic        clear_data_interrupt,
    input  logic        mask_data_interrupt,
    input  logic        set_send_data,
    input  logic [7:0]  send_data,
    output logic [7:0]  received_data,
    output logic [15:0] data_crc,
    output logic        is_in_connecting,
    output logic        sent_data_interrupt,
    output logic        received_data_interrupt,
    output logic        start_bit_timeout,
    output logic        mmc_clock,
    output logic        mmc_data_out,
    output logic        mmc_data_oe,
    input  logic        mmc_data_in
);

    localparam int DIV_W  = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
    localparam int HUNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLOCK_DIV - 1);
    localparam logic [HUNT_W-1:0] HUNT_LAST = HUNT_W'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        SHIFT,
        DONE
    } state_t;

    state_t state, next_state;

    logic [DIV_W-1:0]  div_cnt;
    logic [HUNT_W-1:0] hunt_cnt;
    logic [2:0]        bit_cnt;
    logic              clk_reg;
    logic              dout_reg;
    logic              dir_rx;
    logic              hunt_zero;
    logic [7:0]        tx_reg;
    logic [7:0]        tx_shift;
    logic [7:0]        rx_shift;
    logic [7:0]        rx_data;
    logic [15:0]       crc;
    logic              timeout_reg;
    logic              sent_flag;
    logic              recv_flag;

    logic active;
    logic phase_end;
    logic rise_tick;
    logic fall_tick;
    logic start_accept;
    logic sent_set;
    logic recv_set;

    // One CRC16-CCITT step (poly 0x1021), MSB first.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Phase timing: each mmc_clock half-period lasts CLOCK_DIV clocks. The
    // rise tick is the edge that raises mmc_clock (sample point), the fall
    // tick is the edge that ends a bit period.
    assign active    = (state == HUNT) || (state == SHIFT);
    assign phase_end = (div_cnt == DIV_LAST);
    assign rise_tick = active && phase_end && !clk_reg;
    assign fall_tick = active && phase_end && clk_reg;

    // Completion events feeding the sticky interrupt flags. A hunt that sees
    // no start bit still completes as a (failed) receive.
    assign sent_set = (state == SHIFT) && fall_tick && (bit_cnt == 3'd0) && !dir_rx;
    assign recv_set = ((state == SHIFT) && fall_tick && (bit_cnt == 3'd0) && dir_rx)
                   || ((state == HUNT) && fall_tick && !hunt_zero && (hunt_cnt == HUNT_LAST));

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        next_state       = state;
        start_accept     = 1'b0;
        is_in_connecting = active;
        mmc_data_oe      = (state == SHIFT) && !dir_rx;
        case (state)
            IDLE: begin
                if (start_communication) begin
                    start_accept = 1'b1;
                    next_state   = (data_io && check_data_start_bit) ? HUNT : SHIFT;
                end
            end
            HUNT: begin
                if (fall_tick) begin
                    if (hunt_zero) begin
                        next_state = SHIFT;
                    end else if (hunt_cnt == HUNT_LAST) begin
                        next_state = DONE;
                    end
                end
            end
            SHIFT: begin
                if (fall_tick && (bit_cnt == 3'd0)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Transmit register; loadable at any time. The shifter works from its
    // own copy taken at start, so a load mid-send only affects the next byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_reg <= 8'hFF;
        end else if (set_send_data) begin
            tx_reg <= send_data;
        end
    end

    // Bit engine: mmc_clock generation, DAT0 drive/sample, CRC and
    // received byte. The start bit found by the hunt is neither shifted
    // nor folded into the CRC.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt     <= '0;
            hunt_cnt    <= '0;
            bit_cnt     <= 3'd7;
            clk_reg     <= 1'b1;
            dout_reg    <= 1'b1;
            dir_rx      <= 1'b0;
            hunt_zero   <= 1'b0;
            tx_shift    <= 8'hFF;
            rx_shift    <= 8'h00;
            rx_data     <= 8'h00;
            crc         <= 16'h0000;
            timeout_reg <= 1'b0;
        end else if (start_accept) begin
            div_cnt     <= '0;
            hunt_cnt    <= '0;
            bit_cnt     <= 3'd7;
            clk_reg     <= 1'b0;
            dir_rx      <= data_io;
            hunt_zero   <= 1'b0;
            tx_shift    <= {tx_reg[6:0], 1'b1};
            dout_reg    <= data_io ? 1'b1 : tx_reg[7];
            timeout_reg <= 1'b0;
            if (clear_data_crc) begin
                crc <= 16'h0000;
            end
        end else if (active) begin
            if (!phase_end) begin
                div_cnt <= div_cnt + DIV_W'(1);
            end else begin
                div_cnt <= '0;
                if (rise_tick) begin
                    clk_reg <= 1'b1;
                    if (state == HUNT) begin
                        hunt_zero <= !mmc_data_in;
                    end else begin
                        crc      <= crc_step(crc, dir_rx ? mmc_data_in : dout_reg);
                        rx_shift <= {rx_shift[6:0], mmc_data_in};
                    end
                end else if (state == HUNT) begin
                    if (hunt_zero) begin
                        clk_reg <= 1'b0;
                    end else if (hunt_cnt == HUNT_LAST) begin
                        rx_data     <= 8'hFF;
                        timeout_reg <= 1'b1;
                    end else begin
                        hunt_cnt <= hunt_cnt + HUNT_W'(1);
                        clk_reg  <= 1'b0;
                    end
                end else begin
                    if (bit_cnt == 3'd0) begin
                        dout_reg <= 1'b1;
                        if (dir_rx) begin
                            rx_data <= rx_shift;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 3'd1;
                        clk_reg <= 1'b0;
                        if (!dir_rx) begin
                            dout_reg <= tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b1};
                        end
                    end
                end
            end
        end
    end

    // Sticky completion flags. A set beats a same-cycle clear; starting a
    // new transfer also clears them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sent_flag <= 1'b0;
            recv_flag <= 1'b0;
        end else begin
            if (sent_set) begin
                sent_flag <= 1'b1;
            end else if (start_accept || clear_data_interrupt) begin
                sent_flag <= 1'b0;
            end
            if (recv_set) begin
                recv_flag <= 1'b1;
            end else if (start_accept || clear_data_interrupt) begin
                recv_flag <= 1'b0;
            end
        end
    end

    assign received_data           = rx_data;
    assign data_crc                = crc;
    assign start_bit_timeout       = timeout_reg;
    assign mmc_clock               = clk_reg;
    assign mmc_data_out            = dout_reg;
    assign sent_data_interrupt     = sent_flag & ~mask_data_interrupt;
    assign received_data_interrupt = recv_flag & ~mask_data_interrupt;

endmodule

// File: tb/tb_kfmmc_data_serial.sv
// tb_kfmmc_data_serial
// Self-checking bench for kfmmc_data_serial. Expected transfer results are
// pushed to a scoreboard queue when a transfer is requested and popped when
// the DUT reports completion. Reference CRC and timing come from a small
// behavioural model of the serial protocol.
module tb_kfmmc_data_serial;

    localparam int CLOCK_DIV     = 1;
    localparam int START_TIMEOUT = 4;

    logic        clock;
    logic        reset;
    logic        start_communication;
    logic        data_io;
    logic        check_data_start_bit;
    logic        clear_data_crc;
    logic        clear_data_interrupt;
    logic        mask_data_interrupt;
    logic        set_send_data;
    logic [7:0]  send_data;
    logic [7:0]  received_data;
    logic [15:0] data_crc;
    logic        is_in_connecting;
    logic        sent_data_interrupt;
    logic        received_data_interrupt;
    logic        start_bit_timeout;
    logic        mmc_clock;
    logic        mmc_data_out;
    logic        mmc_data_oe;
    logic        mmc_data_in;

    kfmmc_data_serial #(
        .CLOCK_DIV    (CLOCK_DIV),
        .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .start_communication    (start_communication),
        .data_io                (data_io),
        .check_data_start_bit   (check_data_start_bit),
        .clear_data_crc         (clear_data_crc),
        .clear_data_interrupt   (clear_data_interrupt),
        .mask_data_interrupt    (mask_data_interrupt),
        .set_send_data          (set_send_data),
        .send_data              (send_data),
        .received_data          (received_data),
        .data_crc               (data_crc),
        .is_in_connecting       (is_in_connecting),
        .sent_data_interrupt    (sent_data_interrupt),
        .received_data_interrupt(received_data_interrupt),
        .start_bit_timeout      (start_bit_timeout),
        .mmc_clock              (mmc_clock),
        .mmc_data_out           (mmc_data_out),
        .mmc_data_oe            (mmc_data_oe),
        .mmc_data_in            (mmc_data_in)
    );

    typedef struct {
        logic [7:0]  rx;
        logic [15:0] crc;
        logic        is_rx;
        logic        tmo;
        int          done_at;
        logic [7:0]  tx;
    } exp_t;

    exp_t sb[$];
    logic bit_stream[$];

    int          vec_count   = 0;
    int          miscompares = 0;
    logic [15:0] model_crc   = 16'h0000;
    logic [7:0]  model_rx    = 8'h00;

    always #5 clock = ~clock;

    function automatic logic [15:0] model_crc_bit(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Push the reference outcome of one transfer. ones = number of 1s the
    // bench presents before the start bit when hunting.
    task automatic queue_expect(input logic dio, input logic chk, input logic clr,
                                input logic [7:0] byte_v, input int ones, input logic tmo);
        exp_t e;
        if (clr) model_crc = 16'h0000;
        if (tmo) begin
            model_rx  = 8'hFF;
            e.done_at = 1 + 2 * CLOCK_DIV * START_TIMEOUT;
        end else begin
            for (int i = 7; i >= 0; i--) model_crc = model_crc_bit(model_crc, byte_v[i]);
            if (dio) model_rx = byte_v;
            e.done_at = 1 + 16 * CLOCK_DIV + (chk ? 2 * CLOCK_DIV * (ones + 1) : 0);
        end
        e.rx    = model_rx;
        e.crc   = model_crc;
        e.is_rx = dio;
        e.tmo   = tmo;
        e.tx    = byte_v;
        sb.push_back(e);
    endtask

    // Issue a transfer at the current negedge, feed DAT0 from bit_stream,
    // capture the transmitted byte, then pop and compare at completion.
    // Optionally injects a start plus a transmit-register load at cycle
    // inject_at while busy. Returns at the negedge of the following IDLE cycle.
    task automatic run_transfer(input logic dio, input logic chk, input logic clr,
                                input int inject_at, input logic [7:0] inject_byte,
                                input string tag);
        exp_t e;
        int   n;
        logic prev_clk;
        logic [7:0] sent;
        logic oe_bad;
        logic timed_out;
        start_communication  = 1'b1;
        data_io              = dio;
        check_data_start_bit = chk;
        clear_data_crc       = clr;
        @(negedge clock);
        start_communication  = 1'b0;
        check_data_start_bit = 1'b0;
        clear_data_crc       = 1'b0;
        n = 1; prev_clk = 1'b1; sent = 8'h00; oe_bad = 1'b0; timed_out = 1'b0;
        while (1) begin
            if (mmc_clock === 1'b0 && prev_clk === 1'b1) begin
                mmc_data_in = (bit_stream.size() > 0) ? bit_stream.pop_front() : 1'b1;
                if (!dio) sent = {sent[6:0], mmc_data_out};
            end
            if (is_in_connecting === 1'b1 && mmc_data_oe !== !dio) oe_bad = 1'b1;
            if (n == inject_at) begin
                start_communication = 1'b1;
                data_io             = ~dio;
                clear_data_crc      = 1'b1;
                set_send_data       = 1'b1;
                send_data           = inject_byte;
            end else if (n == inject_at + 1) begin
                start_communication = 1'b0;
                data_io             = dio;
                clear_data_crc      = 1'b0;
                set_send_data       = 1'b0;
            end
            prev_clk = mmc_clock;
            if (is_in_connecting !== 1'b1) break;
            if (n >= 2000) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clock);
            n++;
        end
        vec_count++;
        if (timed_out) begin
            miscompares++;
            $display("[TB] FAIL %s completion: still busy after %0d cycles, wanted done", tag, n);
        end
        if (sb.size() == 0) begin
            vec_count++;
            miscompares++;
            $display("[TB] FAIL %s scoreboard: got empty queue, wanted an entry", tag);
            return;
        end
        e = sb.pop_front();
        vec_count++;
        if (n != e.done_at) begin
            miscompares++;
            $display("[TB] FAIL %s done_cycle: got %0d want %0d", tag, n, e.done_at);
        end
        vec_count++;
        if (sent_data_interrupt !== !e.is_rx) begin
            miscompares++;
            $display("[TB] FAIL %s sent_int: got %b want %b", tag, sent_data_interrupt, !e.is_rx);
        end
        vec_count++;
        if (received_data_interrupt !== e.is_rx) begin
            miscompares++;
            $display("[TB] FAIL %s recv_int: got %b want %b", tag, received_data_interrupt, e.is_rx);
        end
        vec_count++;
        if (received_data !== e.rx) begin
            miscompares++;
            $display("[TB] FAIL %s received_data: got %h want %h", tag, received_data, e.rx);
        end
        vec_count++;
        if (data_crc !== e.crc) begin
            miscompares++;
            $display("[TB] FAIL %s data_crc: got %h want %h", tag, data_crc, e.crc);
        end
        vec_count++;
        if (start_bit_timeout !== e.tmo) begin
            miscompares++;
            $display("[TB] FAIL %s timeout: got %b want %b", tag, start_bit_timeout, e.tmo);
        end
        vec_count++;
        if (oe_bad !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s oe_during_xfer: got wrong oe, want %b", tag, !dio);
        end
        vec_count++;
        if ({mmc_clock, mmc_data_out, mmc_data_oe} !== 3'b110) begin
            miscompares++;
            $display("[TB] FAIL %s done_pins: got %b want 110", tag, {mmc_clock, mmc_data_out, mmc_data_oe});
        end
        if (!dio) begin
            vec_count++;
            if (sent !== e.tx) begin
                miscompares++;
                $display("[TB] FAIL %s sent_bits: got %h want %h", tag, sent, e.tx);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        vec_count++;
        if ({mmc_clock, mmc_data_out, mmc_data_oe, is_in_connecting} !== 4'b1100) begin
            miscompares++;
            $display("[TB] FAIL reset_pins: got %b want 1100", {mmc_clock, mmc_data_out, mmc_data_oe, is_in_connecting});
        end
        vec_count++;
        if ({received_data, data_crc} !== 24'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %h want 000000", {received_data, data_crc});
        end
        vec_count++;
        if ({sent_data_interrupt, received_data_interrupt, start_bit_timeout} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b want 000", {sent_data_interrupt, received_data_interrupt, start_bit_timeout});
        end
        reset = 1'b0;
        @(negedge clock);
        model_crc = 16'h0000;
        model_rx  = 8'h00;
    endtask

    task automatic test_send();
        set_send_data = 1'b1;
        send_data     = 8'h01;
        @(negedge clock);
        set_send_data = 1'b0;
        queue_expect(1'b0, 1'b0, 1'b1, 8'h01, 0, 1'b0);
        run_transfer(1'b0, 1'b0, 1'b1, -10, 8'h00, "send01");
        vec_count++;
        if (data_crc !== 16'h1021) begin
            miscompares++;
            $display("[TB] FAIL send01_crc_const: got %h want 1021", data_crc);
        end
    endtask

    task automatic test_crc_accum();
        set_send_data = 1'b1;
        send_data     = 8'h00;
        @(negedge clock);
        set_send_data = 1'b0;
        queue_expect(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0);
        run_transfer(1'b0, 1'b0, 1'b0, -10, 8'h00, "send00_accum");
        vec_count++;
        if (data_crc !== 16'h3331) begin
            miscompares++;
            $display("[TB] FAIL accum_crc_const: got %h want 3331", data_crc);
        end
        queue_expect(1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0);
        run_transfer(1'b0, 1'b0, 1'b1, -10, 8'h00, "send00_clear");
    endtask

    task automatic test_receive();
        for (int i = 7; i >= 0; i--) bit_stream.push_back(1'b1);
        queue_expect(1'b1, 1'b0, 1'b1, 8'hFF, 0, 1'b0);
        run_transfer(1'b1, 1'b0, 1'b1, -10, 8'h00, "recvFF");
        vec_count++;
        if (data_crc !== 16'h1EF0) begin
            miscompares++;
            $display("[TB] FAIL recvFF_crc_const: got %h want 1ef0", data_crc);
        end
    endtask

    task automatic test_timeout();
        bit_stream.delete();
        queue_expect(1'b1, 1'b1, 1'b0, 8'hFF, 0, 1'b1);
        run_transfer(1'b1, 1'b1, 1'b0, -10, 8'h00, "hunt_timeout");
    endtask

    task automatic test_mask_clear();
        mask_data_interrupt = 1'b1;
        @(negedge clock);
        vec_count++;
        if ({sent_data_interrupt, received_data_interrupt} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL mask_on: got %b want 00", {sent_data_interrupt, received_data_interrupt});
        end
        mask_data_interrupt = 1'b0;
        @(negedge clock);
        vec_count++;
        if (received_data_interrupt !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mask_off: got %b want 1", received_data_interrupt);
        end
        clear_data_interrupt = 1'b1;
        @(negedge clock);
        clear_data_interrupt = 1'b0;
        vec_count++;
        if ({sent_data_interrupt, received_data_interrupt, start_bit_timeout} !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL clear_int: got %b want 001", {sent_data_interrupt, received_data_interrupt, start_bit_timeout});
        end
    endtask

    task automatic test_hunt();
        logic [7:0] b;
        b = 8'hCD;
        bit_stream.delete();
        bit_stream.push_back(1'b1);
        bit_stream.push_back(1'b1);
        bit_stream.push_back(1'b1);
        bit_stream.push_back(1'b0);
        for (int i = 7; i >= 0; i--) bit_stream.push_back(b[i]);
        queue_expect(1'b1, 1'b1, 1'b1, b, 3, 1'b0);
        run_transfer(1'b1, 1'b1, 1'b1, -10, 8'h00, "huntCD");
    endtask

    // A start during SHIFT must be ignored; the load made at that moment
    // is transmitted by the immediately following transfer.
    task automatic test_start_ignored();
        set_send_data = 1'b1;
        send_data     = 8'hA5;
        @(negedge clock);
        set_send_data = 1'b0;
        queue_expect(1'b0, 1'b0, 1'b1, 8'hA5, 0, 1'b0);
        run_transfer(1'b0, 1'b0, 1'b1, 5, 8'h3C, "sendA5_ignore");
    endtask

    task automatic test_back_to_back();
        queue_expect(1'b0, 1'b0, 1'b0, 8'h3C, 0, 1'b0);
        run_transfer(1'b0, 1'b0, 1'b0, -10, 8'h00, "send3C_b2b");
        for (int i = 7; i >= 0; i--) bit_stream.push_back(((8'h96 >> i) & 8'h01) != 8'h00);
        queue_expect(1'b1, 1'b0, 1'b0, 8'h96, 0, 1'b0);
        run_transfer(1'b1, 1'b0, 1'b0, -10, 8'h00, "recv96_b2b");
    endtask

    task automatic test_reset_mid();
        bit_stream.delete();
        start_communication = 1'b1;
        data_io             = 1'b1;
        @(negedge clock);
        start_communication = 1'b0;
        repeat (5) @(negedge clock);
        vec_count++;
        if (is_in_connecting !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midreset_busy: got %b want 1", is_in_connecting);
        end
        reset = 1'b1;
        #1;
        vec_count++;
        if ({mmc_clock, is_in_connecting, received_data} !== {1'b1, 1'b0, 8'h00}) begin
            miscompares++;
            $display("[TB] FAIL midreset_state: got %b_%b_%h want 1_0_00", mmc_clock, is_in_connecting, received_data);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        vec_count++;
        if ({is_in_connecting, received_data_interrupt, data_crc} !== 18'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_after: got %h want 0", {is_in_connecting, received_data_interrupt, data_crc});
        end
    endtask

    initial begin
        clock                = 1'b0;
        reset                = 1'b1;
        start_communication  = 1'b0;
        data_io              = 1'b0;
        check_data_start_bit = 1'b0;
        clear_data_crc       = 1'b0;
        clear_data_interrupt = 1'b0;
        mask_data_interrupt  = 1'b0;
        set_send_data        = 1'b0;
        send_data            = 8'h00;
        mmc_data_in          = 1'b1;
        test_reset();
        test_send();
        test_crc_accum();
        test_receive();
        test_timeout();
        test_mask_clear();
        test_hunt();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
